pipe_mux: RTL
=============

PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, number of input channels (legal 2..16).
REQ-002 The module SHALL have parameter WIDTH, default 8, data width per channel.
REQ-003 The module SHALL have parameter MODE, default MODE_SEL, channel selection mode (MODE_SEL = external select, MODE_RR = round-robin).
REQ-004 The module SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 The module SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 The module SHALL have port valid_i  input  NUM_CH  per-channel input valid.
REQ-007 The module SHALL have port data_i  input  NUM_CH x WIDTH  per-channel input data.
REQ-008 The module SHALL have port ready_o  output  NUM_CH  per-channel accept, high only on the channel being taken this cycle.
REQ-009 The module SHALL have port sel_i  input  $clog2(NUM_CH)  channel select, used only in MODE_SEL.
REQ-010 The module SHALL have port valid_o  output  1  output register holds data.
REQ-011 The module SHALL have port data_o  output  WIDTH  registered selected data.
REQ-012 The module SHALL have port ch_o  output  $clog2(NUM_CH)  index of the channel that supplied data_o.
REQ-013 The module SHALL have port ready_i  input  1  downstream accept.

Function
REQ-014 The module SHALL contain one output register stage (data_o, ch_o, valid_o); latency from input handshake to valid_o = 1 cycle.
REQ-015 The module SHALL have a load-enable ld = !valid_o || ready_i; the register loads only when ld = 1.
REQ-016 In MODE_SEL, the candidate SHALL be sel_i; grant when valid_i[sel_i] = 1 and ld = 1; sel_i >= NUM_CH grants nothing.
REQ-017 In MODE_RR, the candidate SHALL be the first channel with valid_i = 1 searching upward from pointer ptr, wrapping NUM_CH-1 -> 0.
REQ-018 On an RR grant to channel g, ptr SHALL become g+1 modulo NUM_CH; ptr SHALL be unchanged when no grant occurs.
REQ-019 ready_o[g] SHALL be high combinationally in exactly the grant cycle; at most one ready_o bit SHALL be high per cycle.
REQ-020 On grant, the module SHALL set valid_o = 1, data_o = data_i[g], ch_o = g at the next edge.
REQ-021 When ld = 1 and no grant occurs, valid_o SHALL go to 0 at the next edge; data_o and ch_o SHALL hold their previous values.
REQ-022 While valid_o = 1 and ready_i = 0, data_o and ch_o SHALL be stable and no ready_o bit SHALL be high.
REQ-023 Simultaneous output drain and new grant (valid_o = 1, ready_i = 1, grant) SHALL sustain 1 transfer per cycle with no bubble.
REQ-024 A channel with valid_i = 1 SHALL, in MODE_RR, be granted within NUM_CH output transfers (no starvation).

Reset
REQ-025 On reset_n = 0, the module SHALL asynchronously clear valid_o = 0, data_o = 0, ch_o = 0 and ptr = 0, discarding any held word.
REQ-026 While reset_n = 0, all ready_o bits SHALL be 0.
REQ-027 Reset deassertion SHALL take effect synchronously; the first grant is possible on the first edge after release.

Structure
REQ-028 A package pipe_mux_pkg SHALL hold the mode enum (MODE_SEL, MODE_RR) and the NUM_CH legality bounds.
REQ-029 The round-robin search plus pointer SHALL be a sub-module rr_arbiter (NUM_CH parameter; req in, one-hot grant out, advance enable); it is instantiated only for MODE_RR.

Verification
REQ-030 MODE_SEL, NUM_CH=4, WIDTH=8: valid_i=4'b0100, data_i[2]=8'hA5, sel_i=2, ready_i=1 -> ready_o=4'b0100; next cycle valid_o=1, data_o=8'hA5, ch_o=2.
REQ-031 MODE_SEL backpressure: hold ready_i=0 for 3 cycles after valid_o rises -> data_o/ch_o stable and ready_o=0 for those cycles; ready_i=1 with new valid word -> back-to-back transfer, no bubble.
REQ-032 MODE_RR: all 4 valid_i high continuously, ready_i=1 -> ch_o sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 MODE_RR wrap: ptr=3, only valid_i[1]=1 -> grant 1, ptr becomes 2; then only valid_i[3] and valid_i[0] high -> grant 3, then 0.
REQ-034 Reset mid-operation: valid_o=1, ready_i=0, ptr=2, assert reset_n=0 between edges -> valid_o=0, data_o=0, ch_o=0 immediately; after release first RR grant searches from channel 0.
REQ-035 Edge cases: NUM_CH=3 MODE_SEL with sel_i=3 -> no ready_o, valid_o falls to 0; NUM_CH=2 WIDTH=32 MODE_RR alternating grants with data 32'hDEADBEEF / 32'h12345678.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// pipe_mux_pkg -- shared definitions for the pipelined channel multiplexer.
//   mode_e      : channel selection mode (external select or round-robin)
//   NUM_CH_MIN  : smallest supported channel count
//   NUM_CH_MAX  : largest supported channel count
package pipe_mux_pkg;

  typedef enum logic [0:0] {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;

endpackage

// File: rtl/pipe_mux_rr_arbiter.sv
// rr_arbiter -- round-robin requester search with a rotating start pointer.
//   clk      : clock, state on rising edge
//   reset_n  : asynchronous active-low reset, clears the pointer to 0
//   req      : per-channel request vector
//   advance  : the caller consumes the current grant this cycle
//   grant    : one-hot grant (first requester at or above the pointer, wrapping)
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int PW = $clog2(NUM_CH);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] gidx_s;
  logic          found_s;
  logic          hit_s;
  int            idx_s;

  // Search upward from the pointer; the first requester seen wins.
  always_comb begin
    grant   = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_s        = (int'(ptr_r) + i) % NUM_CH;
      hit_s        = req[idx_s] && !found_s;
      grant[idx_s] = hit_s;
      gidx_s       = hit_s ? idx_s[PW-1:0] : gidx_s;
      found_s      = found_s | hit_s;
    end
  end

  // Pointer moves just past the winner, only when the grant is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= (gidx_s == PW'(NUM_CH - 1)) ? '0 : gidx_s + 1'b1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/pipe_mux.sv
// pipe_mux -- NUM_CH-to-1 multiplexer with a single registered output stage.
//   clk      : clock, state on rising edge
//   reset_n  : asynchronous active-low reset
//   valid_i  : per-channel input valid
//   data_i   : per-channel input data
//   ready_o  : per-channel accept, one-hot, high only in the grant cycle
//   sel_i    : channel select (MODE_SEL only)
//   valid_o  : output register holds a word
//   data_o   : registered selected data
//   ch_o     : channel that supplied data_o
//   ready_i  : downstream accept
module pipe_mux
  import pipe_mux_pkg::*;
#(
  parameter int    NUM_CH = 4,
  parameter int    WIDTH  = 8,
  parameter mode_e MODE   = MODE_SEL
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              valid_i,
  input  logic [NUM_CH-1:0][WIDTH-1:0]   data_i,
  output logic [NUM_CH-1:0]              ready_o,
  input  logic [$clog2(NUM_CH)-1:0]      sel_i,
  output logic                           valid_o,
  output logic [WIDTH-1:0]               data_o,
  output logic [$clog2(NUM_CH)-1:0]      ch_o,
  input  logic                           ready_i
);

  localparam int SW = $clog2(NUM_CH);

  logic              ld_s;
  logic [NUM_CH-1:0] cand_s;
  logic [NUM_CH-1:0] grant_s;
  logic [SW-1:0]     gidx_s;
  logic [WIDTH-1:0]  dsel_s;

  // The register can take a new word when empty or being drained.
  assign ld_s    = !valid_o || ready_i;
  assign grant_s = ld_s ? cand_s : '0;
  // Gate with reset so no channel sees an accept while the block is held.
  assign ready_o = grant_s & {NUM_CH{reset_n}};

  if (MODE == MODE_RR) begin : g_rr
    rr_arbiter #(
      .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (valid_i),
      .advance (ld_s),
      .grant   (cand_s)
    );
  end else begin : g_sel
    // Out-of-range select values match no channel and so grant nothing.
    always_comb begin
      cand_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cand_s[i] = valid_i[i] && (sel_i == SW'(i));
      end
    end
  end

  // One-hot grant to channel index and AND-OR data mux.
  always_comb begin
    gidx_s = '0;
    dsel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gidx_s = gidx_s | (SW'(i) & {SW{grant_s[i]}});
      dsel_s = dsel_s | (data_i[i] & {WIDTH{grant_s[i]}});
    end
  end

  // Output stage: load on grant, empty on an idle load, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      ch_o    <= '0;
    end else if (ld_s) begin
      if (|grant_s) begin
        valid_o <= 1'b1;
        data_o  <= dsel_s;
        ch_o    <= gidx_s;
      end else begin
        valid_o <= 1'b0;
      end
    end else begin
      valid_o <= valid_o;
    end
  end

endmodule
